mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencer between the execute stage and the multi-cycle `multiplication` unit. On a multiply request it latches operands, drives the multiplier's `mul` input, stalls the pipeline until `ack_mul`, then presents the product for exactly one write-back cycle. It also short-cuts zero operands, aborts on pipeline flush (draining the in-flight multiply) and bounds every wait with a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT/ABORT cycles before forced termination (range 2..255).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: multiply requested (ALU `MUL_EN`); held by requester while `stall`=1.
- `req_a`, `req_b` in 32: multiplicand, multiplier.
- `req_rd` in 5: destination register tag.
- `flush` in 1: kill current request.
- `stall` out 1: freeze upstream pipeline.
- `busy` out 1: state ≠ IDLE.
- `mul_go` out 1: to multiplier `mul` input.
- `mul_a`, `mul_b` out 32: registered operands to multiplier.
- `ack_mul` in 1: multiplier done; product valid in the same cycle.
- `mul_product` in 32: multiplier result (low 32 bits).
- `wb_valid` out 1: one-cycle result strobe.
- `wb_rd` out 5: tag of result.
- `wb_data` out 32: result.
- `err_timeout` out 1: with `wb_valid`, marks a timed-out multiply (`wb_data`=0).

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ABORT. Reset → IDLE. All registered outputs are 0 during reset: `mul_go`, `mul_a`, `mul_b`, `wb_valid`, `wb_rd`, `wb_data`, `err_timeout`, and the timeout counter.
- IDLE, `req_valid`=1, `flush`=0:
  - Capture `req_a`/`req_b`/`req_rd`.
  - Either operand zero → DONE with `wb_data`=0; the multiplier is not started.
  - Otherwise → ISSUE.
- IDLE with `flush`=1: the request is ignored and the state stays IDLE.
- ISSUE: `mul_go`=1; → WAIT; counter cleared.
- WAIT: `mul_go` held at 1; counter increments each cycle.
  - `ack_mul`=1 → latch `mul_product` into `wb_data`, `mul_go`←0, → DONE.
  - Counter reaching `TIMEOUT_CYCLES` without ack → `wb_data`=0, `err_timeout`=1, `mul_go`←0, → DONE.
- DONE: `wb_valid`=1 for exactly this cycle, with `wb_rd`/`wb_data`/`err_timeout` valid; → IDLE. `req_valid` is ignored in DONE (the instruction retires at this edge).
- `flush` in ISSUE or WAIT: `mul_go`←0, no write-back.
  - If `ack_mul`=1 in that same cycle → IDLE (product discarded).
  - Otherwise → ABORT.
- ABORT: `mul_go`=0; waits for `ack_mul` or timeout, discarding the result; → IDLE. `flush` in ABORT has no further effect.
- `ack_mul` arriving in IDLE/DONE is ignored.
- `stall` (combinational) = (IDLE & `req_valid` & ~`flush`) | ISSUE | WAIT | (ABORT & `req_valid`). It is 0 in DONE.
- `err_timeout` is cleared on the next accepted request.

## Timing
- Nonzero multiply, ack k cycles after the first `mul_go` cycle (k≥1):
  - `req_valid` sampled at edge 0.
  - ISSUE occupies cycle 1.
  - `wb_valid` high in cycle k+2.
  - `stall` high from cycle 0 through cycle k+1.
- Zero shortcut: request at edge 0, `wb_valid` in cycle 1. `stall` is high in cycle 0 only.
- Back-to-back: a request held after DONE is accepted on the IDLE cycle that follows. Minimum spacing between `wb_valid` pulses is 2 cycles (zero operands) or k+3 (nonzero).
- `mul_a`/`mul_b` stay stable from ISSUE until leaving WAIT/ABORT.
- Reset deassertion mid-operation: the next state is IDLE, `mul_go`=0, and there is no spurious `wb_valid`.

## Test plan
- A=6, B=7, `ack_mul` after 5 WAIT cycles with product 42 → one `wb_valid`, `wb_data`=42, `wb_rd`=3, `stall` high for exactly 7 cycles, `mul_go` high for 6 cycles.
- A=100, B=0 → `wb_valid` in the next cycle, `wb_data`=0, `mul_go` never asserts, `stall` high 1 cycle.
- Back-to-back: 12×5 (ack 60) then 255×255 (ack 65025) → two `wb_valid` pulses in order (60, then 65025), no duplicate issue, `req_valid` ignored in DONE.
- `flush` in WAIT cycle 2, ack (product 5000) 3 cycles later, new request 3×4 held meanwhile → no write-back of 5000, `stall` high through ABORT, then 3×4 completes with `wb_data`=12.
- `TIMEOUT_CYCLES`=8, ack never arrives → after 8 WAIT cycles `wb_valid`=1, `err_timeout`=1, `wb_data`=0, `mul_go`=0; the next request clears `err_timeout`.
- `rst` low in WAIT cycle 3 → all outputs 0 immediately (asynchronous); after release, IDLE with no `wb_valid`; a new 6×7 request completes normally.

Source files
------------

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer between the execute stage and the multi-cycle multiplier.
// Latency: zero operand -> write-back 1 cycle after accept; otherwise ack delay k -> write-back k+2 cycles after accept.
// Backpressure: stall freezes the upstream pipeline while a request is pending, in flight, or held during an abort drain.
module mul_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        mul_go,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        ack_mul,
   input  logic [31:0] mul_product,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   // Counter value seen in the last permitted WAIT/ABORT cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        mul_go_q, mul_go_d;
   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   // Next-state and registered-output logic; flush outranks ack, ack outranks timeout.
   always_comb begin
      state_d    = state_q;
      mul_go_d   = mul_go_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               mul_a_d = req_a;
               mul_b_d = req_b;
               wb_rd_d = req_rd;
               err_d   = 1'b0;
               if (req_a == 32'd0 || req_b == 32'd0) begin
                  // Product is known to be zero: skip the multiplier entirely.
                  wb_data_d  = 32'd0;
                  wb_valid_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  mul_go_d = 1'b1;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = 8'd0;
            if (flush) begin
               mul_go_d = 1'b0;
               state_d  = ack_mul ? S_IDLE : S_ABORT;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (flush) begin
               // Multiplier may still be running; drain it in ABORT unless it finishes now.
               mul_go_d = 1'b0;
               cnt_d    = 8'd0;
               state_d  = ack_mul ? S_IDLE : S_ABORT;
            end else if (ack_mul) begin
               wb_data_d  = mul_product;
               mul_go_d   = 1'b0;
               wb_valid_d = 1'b1;
               state_d    = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               wb_data_d  = 32'd0;
               err_d      = 1'b1;
               mul_go_d   = 1'b0;
               wb_valid_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            // Instruction retires on this edge; any req_valid seen here belongs to it.
            state_d = S_IDLE;
         end
         S_ABORT: begin
            mul_go_d = 1'b0;
            cnt_d    = cnt_q + 8'd1;
            if (ack_mul || cnt_q == TO_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            mul_go_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         mul_go_q   <= 1'b0;
         mul_a_q    <= 32'd0;
         mul_b_q    <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         err_q      <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         mul_go_q   <= mul_go_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Stall is gated by reset so the pipeline sees no freeze while the block is held in reset.
   always_comb begin
      stall = rst & ((state_q == S_IDLE && req_valid && !flush) ||
                     state_q == S_ISSUE || state_q == S_WAIT ||
                     (state_q == S_ABORT && req_valid));
   end

   assign busy        = (state_q != S_IDLE);
   assign mul_go      = mul_go_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Testbench for mul_ctrl: directed vector table plus flush and reset sequences.
// Latency: each vector runs to its write-back strobe or a 40-cycle budget.
// Backpressure: requester holds req_valid until the write-back cycle, as the stalled pipeline would.
module tb_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_rd;
   logic        flush;
   logic        stall, busy, mul_go;
   logic [31:0] mul_a, mul_b;
   logic        ack_mul;
   logic [31:0] mul_product;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_rd(req_rd), .flush(flush), .stall(stall), .busy(busy), .mul_go(mul_go),
      .mul_a(mul_a), .mul_b(mul_b), .ack_mul(ack_mul), .mul_product(mul_product),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err_timeout(err_timeout)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          k;        // ack this many cycles after first mul_go cycle; 0 = never
      logic [31:0] prod;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_cyc;  // cycle of wb_valid, request cycle = 0
      int          exp_stall;
      int          exp_go;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Issue one request and follow it to its write-back.
   task automatic do_op(input vec_t v, input string nm);
      int first_go = -1, wb_cnt = 0, wb_cyc = -1, stall_cnt = 0, go_cnt = 0;
      logic [31:0] d = '0;
      logic [4:0]  r = '0;
      logic        e = 1'b0, go_at_wb = 1'b1, ab_ok = 1'b0;
      logic        done = 1'b0;
      req_valid = 1'b1; req_a = v.a; req_b = v.b; req_rd = v.rd; flush = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         ack_mul     = (v.k > 0 && first_go >= 0 && cyc == first_go + v.k);
         mul_product = ack_mul ? v.prod : 32'hDEAD_BEEF;
         @(negedge clk);
         if (stall) stall_cnt++;
         if (mul_go) begin
            go_cnt++;
            if (first_go < 0) begin
               first_go = cyc;
               ab_ok = (mul_a == v.a) && (mul_b == v.b);
            end
         end
         if (wb_valid) begin
            wb_cnt++; wb_cyc = cyc; d = wb_data; r = wb_rd; e = err_timeout;
            go_at_wb = mul_go; done = 1'b1;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0; ack_mul = 1'b0; mul_product = 32'hDEAD_BEEF;
      chk({nm, " wb_count"}, wb_cnt, 1);
      chk({nm, " wb_data"}, d, v.exp_data);
      chk({nm, " wb_rd"}, {27'd0, r}, {27'd0, v.rd});
      chk({nm, " err_timeout"}, {31'd0, e}, {31'd0, v.exp_err});
      chk({nm, " wb_cycle"}, wb_cyc, v.exp_cyc);
      chk({nm, " stall_cycles"}, stall_cnt, v.exp_stall);
      chk({nm, " mul_go_cycles"}, go_cnt, v.exp_go);
      chk({nm, " mul_go_at_wb"}, {31'd0, go_at_wb}, 32'd0);
      if (v.exp_go > 0) chk({nm, " operands_at_issue"}, {31'd0, ab_ok}, 32'd1);
   endtask

   initial begin
      // a, b, rd, k, prod, exp_data, exp_err, exp_cyc, exp_stall, exp_go
      vecs[0] = '{32'd6,   32'd7,   5'd3, 5, 32'd42,    32'd42,    1'b0, 7, 7, 6};
      vecs[1] = '{32'd100, 32'd0,   5'd1, 0, 32'd0,     32'd0,     1'b0, 1, 1, 0};
      vecs[2] = '{32'd12,  32'd5,   5'd4, 2, 32'd60,    32'd60,    1'b0, 4, 4, 3};
      vecs[3] = '{32'd255, 32'd255, 5'd5, 1, 32'd65025, 32'd65025, 1'b0, 3, 3, 2};
      vecs[4] = '{32'd0,   32'd9,   5'd6, 0, 32'd0,     32'd0,     1'b0, 1, 1, 0};
      vecs[5] = '{32'hFFFF_FFFF, 32'd2, 5'd7, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 5, 5, 4};
      vecs[6] = '{32'd9,   32'd9,   5'd8, 0, 32'd0,     32'd0,     1'b1, 10, 10, 9};
      vecs[7] = '{32'd3,   32'd3,   5'd9, 1, 32'd9,     32'd9,     1'b0, 3, 3, 2};

      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
      flush = 1'b0; ack_mul = 1'b0; mul_product = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset mul_go", {31'd0, mul_go}, 32'd0);
      chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("reset mul_a", mul_a, 32'd0);
      chk("reset wb_data", wb_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Vectors run back-to-back: each request starts in the IDLE cycle after the previous DONE.
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
         if (i == 6) chk("err_timeout held in idle", {31'd0, err_timeout}, 32'd1);
      end

      // Flush in second WAIT cycle, late ack drained in ABORT, held request then completes.
      begin
         int st = 0, go_bad = 0, a_bad = 0, wbn = 0, wbc = -1;
         logic [31:0] wbd = '0;
         logic st11 = 1'b1, busy12 = 1'b1;
         for (int c = 0; c < 14; c++) begin
            req_valid   = (c <= 11);
            req_a       = (c <= 3) ? 32'd1000 : (c <= 10) ? 32'd3 : 32'd7;
            req_b       = (c <= 3) ? 32'd5    : (c <= 10) ? 32'd4 : 32'd7;
            req_rd      = (c <= 3) ? 5'd10    : (c <= 10) ? 5'd11 : 5'd12;
            flush       = (c == 3) || (c == 11);
            ack_mul     = (c == 6) || (c == 9);
            mul_product = (c == 6) ? 32'd5000 : (c == 9) ? 32'd12 : 32'hDEAD_BEEF;
            @(negedge clk);
            if (c <= 9 && stall) st++;
            if (c >= 4 && c <= 7 && mul_go) go_bad++;
            if (c >= 4 && c <= 6 && mul_a != 32'd1000) a_bad++;
            if (wb_valid) begin wbn++; wbc = c; wbd = wb_data; end
            if (c == 11) st11 = stall;
            if (c == 12) busy12 = busy;
            @(posedge clk); #1;
         end
         req_valid = 1'b0; flush = 1'b0; ack_mul = 1'b0;
         chk("flush wb_count", wbn, 1);
         chk("flush wb_data", wbd, 32'd12);
         chk("flush wb_cycle", wbc, 10);
         chk("flush stall_cycles", st, 10);
         chk("flush mul_go_in_abort", go_bad, 0);
         chk("flush mul_a_stable", a_bad, 0);
         chk("flush_idle stall", {31'd0, st11}, 32'd0);
         chk("flush_idle busy", {31'd0, busy12}, 32'd0);
      end

      // Asynchronous reset in the third WAIT cycle.
      begin
         int bad = 0;
         for (int c = 0; c < 4; c++) begin
            req_valid = 1'b1; req_a = 32'd6; req_b = 32'd7; req_rd = 5'd3;
            @(posedge clk); #1;
         end
         rst_n = 1'b0;
         #1;
         chk("arst mul_go", {31'd0, mul_go}, 32'd0);
         chk("arst mul_a", mul_a, 32'd0);
         chk("arst mul_b", mul_b, 32'd0);
         chk("arst wb_rd", {27'd0, wb_rd}, 32'd0);
         chk("arst wb_data", wb_data, 32'd0);
         chk("arst busy", {31'd0, busy}, 32'd0);
         chk("arst stall", {31'd0, stall}, 32'd0);
         @(posedge clk); #1;
         req_valid = 1'b0;
         rst_n = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wb_valid || busy || mul_go) bad++;
            @(posedge clk); #1;
         end
         chk("post_reset quiet", bad, 0);
         do_op('{32'd6, 32'd7, 5'd13, 2, 32'd42, 32'd42, 1'b0, 4, 4, 3}, "post_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
